// File: rtl/sb_pkg.sv
// Store buffer shared definitions.
// Holds the buffered-store entry layout, the drain FSM state encoding and
// the byte-offset constants used to split an address into word and lane.
package sb_pkg;

  // Entries are stored at a fixed maximum width so one struct type serves
  // every instance; the top zero-extends into it and reads back only the
  // low ADDR_W / DATA_W bits (both parameters must stay <= these limits).
  localparam int SB_MAX_ADDR_W = 64;
  localparam int SB_MAX_DATA_W = 64;

  // Byte lane within a word is addr[BYTE_OFF_W-1:0]; the word address
  // starts at bit WORD_LSB.
  localparam int BYTE_OFF_W = 2;
  localparam int WORD_LSB   = BYTE_OFF_W;
  localparam int BYTE_W     = 8;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } sb_state_e;

  typedef struct packed {
    logic [SB_MAX_ADDR_W-1:0] addr;
    logic [SB_MAX_DATA_W-1:0] data;
    logic                     byte_sel;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-match priority search over the store buffer slots.
// Ports:
//   match - per-slot flag: slot is valid and its word address equals the load
//   tail  - next write slot; tail-1 is the youngest entry, tail the oldest
//   hit   - at least one slot matched
//   idx   - slot index of the youngest matching entry (0 when no hit)
module sb_match #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         match,
  input  logic [$clog2(DEPTH)-1:0] tail,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] slot;

  // Walk slots from oldest (tail) to youngest (tail-1); a later match
  // overwrites an earlier one, so the youngest match is what remains.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = tail + PTR_W'(k);
      if (match[slot]) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer between the M stage and the data cache.
// Stores are queued in a circular FIFO and drained to the cache from the
// head; loads search the buffer and are forwarded from the youngest store
// to the same word, or told to stall when only part of the word is known.
// Ports:
//   clk, reset         - clock (rising edge), asynchronous active-high reset
//   st_*               - store request / accept handshake
//   ld_*               - load lookup request and forwarding result
//   dc_*               - drain write to the data cache and its accept
//   flush_req/done     - request a full drain / one-cycle completion pulse
//   count              - number of occupied entries
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  input  logic                       st_byte,
  output logic                       st_ready,
  input  logic                       ld_valid,
  input  logic [ADDR_W-1:0]          ld_addr,
  input  logic                       ld_byte,
  output logic                       ld_hit,
  output logic [DATA_W-1:0]          ld_data,
  output logic                       ld_conflict,
  output logic                       dc_write,
  output logic [ADDR_W-1:0]          dc_addr,
  output logic [DATA_W-1:0]          dc_data,
  output logic                       dc_byte,
  input  logic                       dc_ready,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  sb_state_e        state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;

  sb_entry_t        entries_q [DEPTH];
  sb_entry_t        wr_entry;
  sb_entry_t        head_e;
  sb_entry_t        hit_e;

  logic             enq, deq;
  logic             nonempty, full;
  logic [DEPTH-1:0] match;
  logic             match_hit;
  logic [PTR_W-1:0] match_idx;
  logic [BYTE_OFF_W-1:0] ld_off;

  // Pick byte lane off of a word (little-endian), zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] byte_lane(input logic [DATA_W-1:0] w,
                                                  input logic [BYTE_OFF_W-1:0] off);
    logic [DATA_W-1:0] r;
    r = '0;
    r[BYTE_W-1:0] = w[{off, 3'b000} +: BYTE_W];
    return r;
  endfunction

  // Zero-extend the low byte of a word to DATA_W.
  function automatic logic [DATA_W-1:0] low_byte(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    r = '0;
    r[BYTE_W-1:0] = w[BYTE_W-1:0];
    return r;
  endfunction

  assign nonempty = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));

  // ---------------------------------------------------------------------
  // Drain and enqueue handshakes
  // ---------------------------------------------------------------------
  // A load in flight owns the cache port unless the buffer is full (stores
  // would otherwise deadlock the M stage) or a flush is draining.
  always_comb begin
    dc_write = nonempty && (!ld_valid || full || (state_q == FLUSH));
    enq      = st_valid && st_ready;
    deq      = dc_write && dc_ready;
  end

  // Head entry drives the cache port; forced to 0 while empty so reset and
  // idle never expose stale slot contents.
  always_comb begin
    head_e  = entries_q[head_q];
    dc_addr = '0;
    dc_data = '0;
    dc_byte = 1'b0;
    if (nonempty) begin
      dc_addr = head_e.addr[ADDR_W-1:0];
      dc_data = head_e.data[DATA_W-1:0];
      dc_byte = head_e.byte_sel;
    end
  end

  // ---------------------------------------------------------------------
  // FIFO pointer / occupancy next-state
  // ---------------------------------------------------------------------
  always_comb begin
    head_d  = deq ? head_q + PTR_W'(1) : head_q;
    tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // enq and deq never target the same slot: that needs head==tail, which
    // means empty (no deq) or full (no enq).
    valid_d = valid_q;
    if (deq) valid_d[head_q] = 1'b0;
    if (enq) valid_d[tail_q] = 1'b1;
  end

  always_comb begin
    wr_entry          = '0;
    wr_entry.addr     = SB_MAX_ADDR_W'(st_addr);
    wr_entry.data     = SB_MAX_DATA_W'(st_data);
    wr_entry.byte_sel = st_byte;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Slot payload is not reset; valid_q alone decides whether it is seen.
  always_ff @(posedge clk) begin
    if (enq) entries_q[tail_q] <= wr_entry;
  end

  // ---------------------------------------------------------------------
  // Load forwarding
  // ---------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i] && ld_valid &&
                 (entries_q[i].addr[ADDR_W-1:WORD_LSB] == ld_addr[ADDR_W-1:WORD_LSB]);
    end
  end

  sb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .match (match),
    .tail  (tail_q),
    .hit   (match_hit),
    .idx   (match_idx)
  );

  // A word store covers every lane; a byte store only covers a byte load of
  // exactly its own lane, anything else must wait for the drain.
  always_comb begin
    hit_e       = entries_q[match_idx];
    ld_off      = ld_addr[BYTE_OFF_W-1:0];
    ld_hit      = 1'b0;
    ld_conflict = 1'b0;
    ld_data     = '0;
    if (match_hit) begin
      if (!hit_e.byte_sel) begin
        ld_hit  = 1'b1;
        ld_data = ld_byte ? byte_lane(hit_e.data[DATA_W-1:0], ld_off)
                          : hit_e.data[DATA_W-1:0];
      end else if (ld_byte && (hit_e.addr[BYTE_OFF_W-1:0] == ld_off)) begin
        ld_hit  = 1'b1;
        ld_data = low_byte(hit_e.data[DATA_W-1:0]);
      end else begin
        ld_conflict = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Flush FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush_req) state_d = FLUSH;
      FLUSH:   if (!nonempty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Stores stop for the whole flush; a slot freed this cycle is not reused
  // until count_q reflects it.
  always_comb begin
    st_ready   = (count_q < CNT_W'(DEPTH)) && (state_q == RUN);
    flush_done = (state_q == FLUSH) && !nonempty;
    count      = count_q;
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based model.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_byte;
  logic          st_ready;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_byte;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          ld_conflict;
  logic          dc_write;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_data;
  logic          dc_byte;
  logic          dc_ready;
  logic          flush_req;
  logic          flush_done;
  logic [CW-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_byte     (st_byte),
    .st_ready    (st_ready),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_byte     (ld_byte),
    .ld_hit      (ld_hit),
    .ld_data     (ld_data),
    .ld_conflict (ld_conflict),
    .dc_write    (dc_write),
    .dc_addr     (dc_addr),
    .dc_data     (dc_data),
    .dc_byte     (dc_byte),
    .dc_ready    (dc_ready),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .count       (count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the buffer is an ordered list of pending stores.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          b;
  } ent_t;

  ent_t q[$];
  bit   flushing;

  logic          e_st_ready, e_ld_hit, e_ld_conflict, e_dc_write, e_dc_byte, e_flush_done;
  logic [DW-1:0] e_ld_data, e_dc_data;
  logic [AW-1:0] e_dc_addr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    int n;
    n = q.size();
    e_st_ready   = (n < DEPTH) && !flushing;
    e_dc_write   = (n > 0) && (!ld_valid || n == DEPTH || flushing);
    e_dc_addr    = (n > 0) ? q[0].a : '0;
    e_dc_data    = (n > 0) ? q[0].d : '0;
    e_dc_byte    = (n > 0) ? q[0].b : 1'b0;
    e_flush_done = flushing && (n == 0);
    e_ld_hit = 1'b0; e_ld_conflict = 1'b0; e_ld_data = '0;
    if (ld_valid) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (q[i].a[AW-1:2] == ld_addr[AW-1:2]) begin
          if (!q[i].b) begin
            e_ld_hit  = 1'b1;
            e_ld_data = ld_byte ? ((q[i].d >> (8 * ld_addr[1:0])) & 32'hFF) : q[i].d;
          end else if (ld_byte && q[i].a[1:0] == ld_addr[1:0]) begin
            e_ld_hit  = 1'b1;
            e_ld_data = q[i].d & 32'hFF;
          end else begin
            e_ld_conflict = 1'b1;
          end
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    model_eval();
    chk("st_ready",    st_ready,    e_st_ready);
    chk("count",       count,       q.size());
    chk("dc_write",    dc_write,    e_dc_write);
    chk("dc_addr",     dc_addr,     e_dc_addr);
    chk("dc_data",     dc_data,     e_dc_data);
    chk("dc_byte",     dc_byte,     e_dc_byte);
    chk("ld_hit",      ld_hit,      e_ld_hit);
    chk("ld_conflict", ld_conflict, e_ld_conflict);
    chk("ld_data",     ld_data,     e_ld_data);
    chk("flush_done",  flush_done,  e_flush_done);
  endtask

  // Apply this cycle's handshakes to the model (inputs are stable until the edge).
  task automatic model_update();
    bit was_empty;
    was_empty = (q.size() == 0);
    if (e_dc_write && dc_ready) void'(q.pop_front());
    if (st_valid && e_st_ready) q.push_back('{a: st_addr, d: st_data, b: st_byte});
    if (flushing && was_empty) flushing = 0;
    else if (!flushing && flush_req) flushing = 1;
  endtask

  task automatic tick_begin();
    @(negedge clk);
  endtask

  task automatic tick_end();
    check_all();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    tick_begin();
    tick_end();
  endtask

  task automatic drive(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic sb, input logic lv, input logic [AW-1:0] la,
                       input logic lb, input logic dr, input logic fr);
    st_valid = sv; st_addr = sa; st_data = sd; st_byte = sb;
    ld_valid = lv; ld_addr = la; ld_byte = lb; dc_ready = dr; flush_req = fr;
  endtask

  task automatic idle(input logic dr);
    drive(0, '0, '0, 0, 0, '0, 0, dr, 0);
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) tick();
    tick_begin();
    chk("drain_empty", count, 0);
    tick_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int writes, dones;

  initial begin
    reset = 1'b1;
    idle(0);
    q.delete();
    flushing = 0;
    #2;
    chk("rst_st_ready",   st_ready, 1);
    chk("rst_count",      count, 0);
    chk("rst_dc_write",   dc_write, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_ld_hit",     ld_hit, 0);
    chk("rst_dc_addr",    dc_addr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Fill to capacity with the cache stalled; a fifth store is refused.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h100 + 4 * i, 32'hC0DE0000 + i, 0, 0, '0, 0, 0, 0);
      tick();
    end
    drive(1, 32'h110, 32'hDEADBEEF, 0, 0, '0, 0, 0, 0);
    tick_begin();
    chk("full_count",    count, 4);
    chk("full_st_ready", st_ready, 0);
    tick_end();
    tick_begin();
    chk("full_count_after_5th", count, 4);
    chk("full_head_addr", dc_addr, 32'h100);
    tick_end();
    drain();

    // Word store, then byte load of lane 2 forwarded zero-extended.
    drive(1, 32'h100, 32'hAABBCCDD, 0, 0, '0, 0, 0, 0);
    tick();
    drive(0, '0, '0, 0, 1, 32'h102, 1, 0, 0);
    tick_begin();
    chk("fwd_byte_hit",  ld_hit, 1);
    chk("fwd_byte_data", ld_data, 32'h000000BB);
    chk("fwd_byte_dcw",  dc_write, 0);
    tick_end();
    drain();

    // Two stores to the same word: the younger one is forwarded.
    drive(1, 32'h200, 32'h11111111, 0, 0, '0, 0, 0, 0);
    tick();
    drive(1, 32'h200, 32'h22222222, 0, 0, '0, 0, 0, 0);
    tick();
    drive(0, '0, '0, 0, 1, 32'h200, 0, 0, 0);
    tick_begin();
    chk("young_hit",  ld_hit, 1);
    chk("young_data", ld_data, 32'h22222222);
    tick_end();
    drain();

    // Byte store vs word load conflicts; same-lane byte load hits.
    drive(1, 32'h301, 32'hFFFFFF5A, 1, 0, '0, 0, 0, 0);
    tick();
    drive(0, '0, '0, 0, 1, 32'h300, 0, 0, 0);
    tick_begin();
    chk("conf_conflict", ld_conflict, 1);
    chk("conf_hit",      ld_hit, 0);
    tick_end();
    drive(0, '0, '0, 0, 1, 32'h301, 1, 0, 0);
    tick_begin();
    chk("byte_lane_hit",  ld_hit, 1);
    chk("byte_lane_data", ld_data, 32'h5A);
    tick_end();
    drain();
    drive(0, '0, '0, 0, 1, 32'h300, 0, 0, 0);
    tick_begin();
    chk("conf_gone_conflict", ld_conflict, 0);
    chk("conf_gone_hit",      ld_hit, 0);
    tick_end();

    // Flush on an empty buffer completes one cycle later.
    drive(0, '0, '0, 0, 0, '0, 0, 1, 1);
    tick();
    idle(1);
    tick_begin();
    chk("empty_flush_done", flush_done, 1);
    chk("empty_flush_st_ready", st_ready, 0);
    tick_end();
    tick_begin();
    chk("empty_flush_back_run", st_ready, 1);
    tick_end();

    // Flush three entries: three drain writes, stores held off, one done pulse.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h500 + 4 * i, 32'h5000 + i, 0, 0, '0, 0, 0, 0);
      tick();
    end
    writes = 0; dones = 0;
    drive(0, '0, '0, 0, 0, '0, 0, 1, 1);
    for (int i = 0; i < 10 && dones == 0; i++) begin
      tick_begin();
      if (dc_write) writes++;
      if (flush_done) dones++;
      if (i > 0) chk("flush_st_ready", st_ready, 0);
      tick_end();
      drive(1, 32'h600, 32'h66, 0, 0, '0, 0, 1, 0);
    end
    idle(1);
    chk("flush_writes", writes, 3);
    chk("flush_dones",  dones, 1);
    tick_begin();
    chk("flush_run_st_ready", st_ready, 1);
    chk("flush_run_count",    count, 0);
    tick_end();

    // Reset in the middle of a drain discards everything immediately.
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h700 + 4 * i, 32'h7000 + i, 0, 0, '0, 0, 0, 0);
      tick();
    end
    idle(1);
    tick_begin();
    chk("pre_rst_dc_write", dc_write, 1);
    chk("pre_rst_count",    count, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_count",    count, 0);
    chk("mid_rst_dc_write", dc_write, 0);
    chk("mid_rst_st_ready", st_ready, 1);
    chk("mid_rst_dc_addr",  dc_addr, 0);
    q.delete();
    flushing = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    tick();

    // Randomized traffic over a few words so forwarding and conflicts recur.
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 1), 32'h400 + $urandom_range(0, 15), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 1), 32'h400 + $urandom_range(0, 15),
            $urandom_range(0, 1), ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0));
      tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
